loopback_dump_core: RTL and testbench

- Parametrised bring-up core for board tests. Occupies the core slot next to the instruction memory and the UART send/receive request blocks.
- Operation is one pass:
  - fetch INSTR_WORDS words from instruction memory;
  - receive RECV_WORDS words from the UART receive FIFO;
  - send all buffered words back over UART, in forward or reverse order.
- Generalises the fixed 10+10-word dummy core with configurable counts, width, ordering and a completion flag.
- Receive requests are flow-controlled, so the core never over-requests.

---
 rtl/loopback_dump_core.sv | 238 +++++++++++++++++++++++
 tb/tb_loopback_dump_core.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loopback_dump_core.sv
// loopback_dump_core
// ------------------
// Board bring-up core that performs a single pass and then stays idle:
//   1. fetches INSTR_WORDS words from instruction memory (addresses 0..INSTR_WORDS-1),
//   2. pops RECV_WORDS words from the UART receive FIFO (never over-requesting),
//   3. sends all buffered words back over UART, in forward or reverse order,
//   4. raises done and stays idle until reset.
//
// Optional feature macro: LOOPBACK_CHECKSUM_EN
//   When defined, one extra word is sent after the data words. It carries the
//   WIDTH-bit wrapping sum of every buffered word and is always sent last.
//   When undefined, no accumulator is built.
//
// Ports:
//   clock        in   1       system clock, all logic on posedge
//   reset        in   1       synchronous, active-low
//   instr_addr   out  32      instruction memory word address
//   instr        in   WIDTH   instruction data, valid one cycle after instr_addr
//   recv_en      out  1       pop request to the receive FIFO (combinational)
//   recv_rd      in   WIDTH   popped word, valid the cycle after recv_en
//   recv_size    in   SIZE_W  words currently held in the receive FIFO
//   send_en      out  1       one-cycle send strobe
//   send_content out  WIDTH   word to send, valid while send_en=1
//   send_busy    in   1       transmitter busy
//   reverse      in   1       order select, latched when FETCH ends
//   done         out  1       high once every word has been sent

module loopback_dump_core #(
    parameter int INSTR_WORDS = 10,
    parameter int RECV_WORDS  = 10,
    parameter int WIDTH       = 32,
    parameter int SIZE_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    output logic [31:0]       instr_addr,
    input  logic [WIDTH-1:0]  instr,
    output logic              recv_en,
    input  logic [WIDTH-1:0]  recv_rd,
    input  logic [SIZE_W-1:0] recv_size,
    output logic              send_en,
    output logic [WIDTH-1:0]  send_content,
    input  logic              send_busy,
    input  logic              reverse,
    output logic              done
);

    localparam int DEPTH = INSTR_WORDS + RECV_WORDS;
    localparam int CW    = $clog2(DEPTH + 2);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] INSTR_N   = CW'(INSTR_WORDS);
    localparam logic [CW-1:0] RECV_N    = CW'(RECV_WORDS);
    localparam logic [CW-1:0] RECV_LAST = CW'(RECV_WORDS - 1);
    localparam logic [CW-1:0] DEPTH_N   = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1  = CW'(DEPTH - 1);

`ifdef LOOPBACK_CHECKSUM_EN
    localparam logic [CW-1:0] SEND_N = CW'(DEPTH + 1);
`else
    localparam logic [CW-1:0] SEND_N = CW'(DEPTH);
`endif

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_RECV,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0]    fcnt;
    logic [CW-1:0]    req_cnt;
    logic [CW-1:0]    got_cnt;
    logic [CW-1:0]    scnt;
    logic             rev_q;
    logic             recv_valid;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] send_word;
    logic             send_fire;

`ifdef LOOPBACK_CHECKSUM_EN
    logic [WIDTH-1:0] csum;
`endif

    // The address follows the fetch counter directly; memory answers one cycle later.
    assign instr_addr = 32'(fcnt);

    // Pops stop at RECV_WORDS requests even if the FIFO still holds words.
    assign recv_en = reset && (state == ST_RECV) && (recv_size != '0) && (req_cnt < RECV_N);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the RECV exit uses only the write-side counter.
    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: begin
                if (fcnt == INSTR_N) begin
                    next_state = ST_RECV;
                end
            end
            ST_RECV: begin
                if (recv_valid && (got_cnt == RECV_LAST)) begin
                    next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if ((scnt == SEND_N) && !send_en) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_DONE;
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase
    end

    // Single buffer write port shared by the fetch and receive phases.
    // Fetch stores the word for the previous address, hence fcnt-1.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if ((state == ST_FETCH) && (fcnt != '0)) begin
            wr_en   = 1'b1;
            wr_idx  = AW'(fcnt - CW'(1));
            wr_data = instr;
        end else if ((state == ST_RECV) && recv_valid) begin
            wr_en   = 1'b1;
            wr_idx  = AW'(INSTR_N + got_cnt);
            wr_data = recv_rd;
        end
    end

    // Read side: pick the buffer slot for the current send count. The
    // checksum slot (if present) sits past the data and ignores ordering.
    always_comb begin
        rd_idx    = rev_q ? AW'(DEPTH_M1 - scnt) : AW'(scnt);
        send_word = '0;
        if (scnt < DEPTH_N) begin
            send_word = mem[rd_idx];
        end
`ifdef LOOPBACK_CHECKSUM_EN
        else begin
            send_word = csum;
        end
`endif
        send_fire = (state == ST_SEND) && !send_busy && !send_en && (scnt < SEND_N);
    end

    // Buffer storage has no reset; its contents are meaningless after reset.
    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

`ifdef LOOPBACK_CHECKSUM_EN
    // Running sum of every word written into the buffer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            csum <= '0;
        end else if (wr_en) begin
            csum <= csum + wr_data;
        end
    end
`endif

    // Counters, order latch, receive pipeline flag and the send strobe.
    // The strobe clears every cycle, and a new one needs send_en low,
    // which gives the two-cycle minimum spacing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fcnt         <= '0;
            req_cnt      <= '0;
            got_cnt      <= '0;
            scnt         <= '0;
            rev_q        <= 1'b0;
            recv_valid   <= 1'b0;
            send_en      <= 1'b0;
            send_content <= '0;
            done         <= 1'b0;
        end else begin
            recv_valid <= recv_en;
            send_en    <= 1'b0;
            done       <= (next_state == ST_DONE);
            case (state)
                ST_FETCH: begin
                    if (fcnt == INSTR_N) begin
                        rev_q <= reverse;
                    end else begin
                        fcnt <= fcnt + CW'(1);
                    end
                end
                ST_RECV: begin
                    if (recv_en) begin
                        req_cnt <= req_cnt + CW'(1);
                    end
                    if (recv_valid) begin
                        got_cnt <= got_cnt + CW'(1);
                    end
                    if (next_state == ST_SEND) begin
                        scnt <= '0;
                    end
                end
                ST_SEND: begin
                    if (send_fire) begin
                        send_en      <= 1'b1;
                        send_content <= send_word;
                        scnt         <= scnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loopback_dump_core.sv
// tb_loopback_dump_core
// ---------------------
// Scoreboard bench for loopback_dump_core with default parameters.
// Inputs are driven on the falling edge; outputs are observed there too.
// Models: synchronous instruction memory (word a = 0x1000+a), a receive
// FIFO with optional timed arrivals, and a transmitter busy timer.
// Expected send words are queued when a pass is set up and popped as
// strobes appear.

module tb_loopback_dump_core;

    localparam int INSTR_WORDS = 10;
    localparam int RECV_WORDS  = 10;
    localparam int DEPTH       = INSTR_WORDS + RECV_WORDS;
`ifdef LOOPBACK_CHECKSUM_EN
    localparam int NSTROBE = DEPTH + 1;
`else
    localparam int NSTROBE = DEPTH;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_addr;
    logic [31:0] instr = '0;
    logic        recv_en;
    logic [31:0] recv_rd = '0;
    logic [15:0] recv_size = '0;
    logic        send_en;
    logic [31:0] send_content;
    logic        send_busy = 1'b0;
    logic        reverse = 1'b0;
    logic        done;

    logic [31:0] exp_q[$];
    logic [31:0] fifo[$];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          strobes = 0;
    int          pops = 0;
    int          last_strobe = -100;
    int          first_en_cyc = -1;
    int          busy_hold = 0;
    int          busy_left = 0;
    int          arrive_left = 0;
    int          arrive_period = 7;
    int          arrive_cnt = 0;
    logic [31:0] arrive_word = '0;
    logic [31:0] last_addr = '0;
    logic        en_at_edge = 1'b0;
    logic        busy_at_edge = 1'b0;

    always #5 clock = ~clock;

    loopback_dump_core dut (
        .clock        (clock),
        .reset        (reset),
        .instr_addr   (instr_addr),
        .instr        (instr),
        .recv_en      (recv_en),
        .recv_rd      (recv_rd),
        .recv_size    (recv_size),
        .send_en      (send_en),
        .send_content (send_content),
        .send_busy    (send_busy),
        .reverse      (reverse),
        .done         (done)
    );

    // One clock of environment: memory, FIFO, strobe monitor, busy timer.
    task automatic step();
        logic [31:0] exp_word;
        @(negedge clock);
        cyc++;
        instr     = 32'h1000 + last_addr;
        last_addr = instr_addr;
        if (en_at_edge) begin
            pops++;
            if (fifo.size() > 0) begin
                recv_rd = fifo.pop_front();
            end else begin
                recv_rd = 32'hDEAD_BEEF;
            end
        end
        if (send_en === 1'b1) begin
            strobes++;
            checks++;
            if (busy_at_edge !== 1'b0) begin
                errors++;
                $display("[TB] FAIL strobe_while_busy: busy=%b at strobe %0d, required 0", busy_at_edge, strobes);
            end
            if (last_strobe >= 0) begin
                checks++;
                if (cyc - last_strobe < 2) begin
                    errors++;
                    $display("[TB] FAIL strobe_gap: gap=%0d cycles, required >=2", cyc - last_strobe);
                end
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL done_early: done=%b at strobe %0d, required 0", done, strobes);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL extra_strobe: got %h, required no strobe", send_content);
            end else begin
                exp_word = exp_q.pop_front();
                if (send_content !== exp_word) begin
                    errors++;
                    $display("[TB] FAIL strobe_data: strobe %0d got %h required %h", strobes, send_content, exp_word);
                end
            end
            last_strobe = cyc;
            busy_left   = busy_hold;
        end
        send_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (arrive_left > 0) begin
            if (arrive_cnt == 0) begin
                fifo.push_back(arrive_word);
                arrive_word = arrive_word + 32'd1;
                arrive_left--;
                arrive_cnt = arrive_period - 1;
            end else begin
                arrive_cnt--;
            end
        end
        recv_size = 16'(fifo.size());
        #1;
        en_at_edge   = recv_en;
        busy_at_edge = send_busy;
        if (recv_en === 1'b1 && first_en_cyc < 0) first_en_cyc = cyc;
        if (recv_size == 16'd0) begin
            checks++;
            if (recv_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL recv_en_on_empty: recv_en=%b with recv_size=0, required 0", recv_en);
            end
        end
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    // Queue the words a full pass should send, plus the checksum if enabled.
    task automatic expect_pass(input logic rev, input logic [31:0] rbase);
        logic [31:0] words[$];
        logic [31:0] sum;
        sum = '0;
        for (int a = 0; a < INSTR_WORDS; a++) words.push_back(32'h1000 + 32'(a));
        for (int r = 0; r < RECV_WORDS; r++) words.push_back(rbase + 32'(r));
        foreach (words[i]) sum = sum + words[i];
        if (!rev) begin
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(words[i]);
        end else begin
            for (int i = DEPTH - 1; i >= 0; i--) exp_q.push_back(words[i]);
        end
`ifdef LOOPBACK_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    // Reset the DUT and set up the environment for one pass.
    task automatic start_pass(input logic rev, input logic [31:0] rbase, input int preload);
        reset = 1'b0;
        reverse = rev;
        fifo.delete();
        exp_q.delete();
        for (int i = 0; i < preload; i++) fifo.push_back(rbase + 32'(i));
        expect_pass(rev, rbase);
        strobes = 0;
        pops = 0;
        last_strobe = -100;
        busy_left = 0;
        step();
        step();
        first_en_cyc = -1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) fifo.push_back(32'h55 + 32'(i));
        step();
        step();
        step();
        checks++;
        if (send_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_send_en: got %b required 0", send_en); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b required 0", done); end
        checks++;
        if (instr_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr_addr: got %h required 0", instr_addr); end
        checks++;
        if (recv_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_recv_en: got %b required 0", recv_en); end
        checks++;
        if (send_content !== 32'd0) begin errors++; $display("[TB] FAIL reset_send_content: got %h required 0", send_content); end
        checks++;
        if (pops !== 0) begin errors++; $display("[TB] FAIL reset_pops: got %0d required 0", pops); end
    endtask

    task automatic test_forward();
        int start;
        $display("[TB] test_forward");
        busy_hold = 0;
        start_pass(1'b0, 32'hA0, 10);
        start = cyc;
        run_until_done(400);
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL fwd_done: got %b required 1", done); end
        checks++;
        if (strobes != NSTROBE) begin errors++; $display("[TB] FAIL fwd_strobes: got %0d required %0d", strobes, NSTROBE); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL fwd_left: %0d words unsent, required 0", exp_q.size()); end
        checks++;
        if (pops != RECV_WORDS) begin errors++; $display("[TB] FAIL fwd_pops: got %0d required %0d", pops, RECV_WORDS); end
        checks++;
        if (first_en_cyc - start != INSTR_WORDS + 1) begin
            errors++;
            $display("[TB] FAIL fetch_length: got %0d cycles required %0d", first_en_cyc - start, INSTR_WORDS + 1);
        end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (done !== 1'b1 || strobes != NSTROBE) begin
            errors++;
            $display("[TB] FAIL fwd_idle: done=%b strobes=%0d, required 1 and %0d", done, strobes, NSTROBE);
        end
    endtask

    task automatic test_reverse();
        $display("[TB] test_reverse");
        busy_hold = 0;
        start_pass(1'b1, 32'hA0, 10);
        run_until_done(400);
        reverse = 1'b0;
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL rev_done: got %b required 1", done); end
        checks++;
        if (strobes != NSTROBE) begin errors++; $display("[TB] FAIL rev_strobes: got %0d required %0d", strobes, NSTROBE); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rev_left: %0d words unsent, required 0", exp_q.size()); end
    endtask

    task automatic test_slow_fifo();
        int n;
        $display("[TB] test_slow_fifo");
        busy_hold = 0;
        start_pass(1'b0, 32'hB0, 0);
        arrive_word = 32'hB0;
        arrive_cnt = arrive_period - 1;
        arrive_left = RECV_WORDS + 1;
        run_until_done(1000);
        n = 0;
        while (arrive_left > 0 && n < 200) begin
            step();
            n++;
        end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL slow_done: got %b required 1", done); end
        checks++;
        if (pops != RECV_WORDS) begin errors++; $display("[TB] FAIL slow_pops: got %0d required %0d", pops, RECV_WORDS); end
        checks++;
        if (fifo.size() != 1) begin
            errors++;
            $display("[TB] FAIL slow_leftover: fifo holds %0d words, required 1", fifo.size());
        end else if (fifo[0] !== 32'hB0 + 32'(RECV_WORDS)) begin
            errors++;
            $display("[TB] FAIL slow_leftover_word: got %h required %h", fifo[0], 32'hB0 + 32'(RECV_WORDS));
        end
        checks++;
        if (exp_q.size() != 0 || strobes != NSTROBE) begin
            errors++;
            $display("[TB] FAIL slow_sent: strobes=%0d left=%0d, required %0d and 0", strobes, exp_q.size(), NSTROBE);
        end
        arrive_left = 0;
    endtask

    task automatic test_busy();
        $display("[TB] test_busy");
        busy_hold = 50;
        start_pass(1'b0, 32'hC0, 10);
        run_until_done(3000);
        busy_hold = 0;
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL busy_done: got %b required 1", done); end
        checks++;
        if (strobes != NSTROBE || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL busy_sent: strobes=%0d left=%0d, required %0d and 0", strobes, exp_q.size(), NSTROBE);
        end
    endtask

    task automatic test_midreset();
        int n;
        $display("[TB] test_midreset");
        busy_hold = 0;
        start_pass(1'b0, 32'hD0, 10);
        n = 0;
        while (strobes < 5 && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (strobes != 5) begin errors++; $display("[TB] FAIL mid_reach5: got %0d strobes required 5", strobes); end
        exp_q.delete();
        fifo.delete();
        for (int i = 0; i < RECV_WORDS; i++) fifo.push_back(32'hD0 + 32'(i));
        expect_pass(1'b0, 32'hD0);
        reset = 1'b0;
        step();
        checks++;
        if (send_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_send_en: got %b required 0", send_en); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done: got %b required 0", done); end
        checks++;
        if (instr_addr !== 32'd0) begin errors++; $display("[TB] FAIL mid_instr_addr: got %h required 0", instr_addr); end
        strobes = 0;
        pops = 0;
        last_strobe = -100;
        reset = 1'b1;
        run_until_done(400);
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL mid_rerun_done: got %b required 1", done); end
        checks++;
        if (strobes != NSTROBE || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL mid_rerun_sent: strobes=%0d left=%0d, required %0d and 0", strobes, exp_q.size(), NSTROBE);
        end
        checks++;
        if (pops != RECV_WORDS) begin errors++; $display("[TB] FAIL mid_rerun_pops: got %0d required %0d", pops, RECV_WORDS); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_slow_fifo();
        test_busy();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
